regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard and same-cycle write-to-read bypass, for the pipelined datapath. It replaces the fixed 32x32, two-read, negedge-write register file. Decode reads operands and busy flags; issue marks a destination busy; writeback writes data and clears busy. The hazard unit consumes `rd_busy` and `busy_any`.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 67 ++++++
 rtl/regfile_sb.sv | 98 +++++++++
 tb/tb_regfile_sb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file and
// the writeback stage.
//   RF_DATA_W / RF_NREGS : default register width and register count
//   rf_wb_t              : writeback bundle {en, addr, data} at default sizes
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_NREGS  = 32;
  localparam int RF_ADDR_W = $clog2(RF_NREGS);

  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wb_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write (busy) bits.
//   clk, rst          : clock, asynchronous active-high reset
//   iss_en, iss_addr  : mark a destination register busy
//   wb_en, wb_addr    : clear the busy bit of the written register
//   flush             : clear every busy bit (a same-cycle issue survives)
//   busy              : registered busy vector, one bit per register
//   busy_cnt          : population count of busy
//   busy_any          : busy_cnt != 0
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt,
  output logic              busy_any
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [ADDR_W:0]  cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      logic iss_hit;
      logic wb_hit;
      // A hardwired zero register can never become a pending destination.
      assign iss_hit = iss_en && (iss_addr == ADDR_W'(gi)) && !(ZERO_REG != 0 && gi == 0);
      assign wb_hit  = wb_en && (wb_addr == ADDR_W'(gi));
      // Issue beats flush (younger than the flush point) and beats
      // writeback (the new producer is still outstanding).
      assign busy_next[gi] = iss_hit ? 1'b1 :
                             flush   ? 1'b0 :
                             wb_hit  ? 1'b0 : busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_reg[i]};
    end
  end

  assign busy     = busy_reg;
  assign busy_cnt = cnt_next;
  assign busy_any = (cnt_next != '0);

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with pending-write scoreboard
// and same-cycle writeback-to-read bypass.
//   clk, rst                 : clock, asynchronous active-high reset
//   rd_addr  [NUM_RD*ADDR_W] : read addresses, port i at bits [i*ADDR_W +: ADDR_W]
//   rd_data  [NUM_RD*DATA_W] : combinational read data (bypassed)
//   rd_busy  [NUM_RD]        : read register has a pending write (bypassed)
//   iss_en, iss_addr         : issue marks a destination busy
//   wb_en, wb_addr, wb_data  : writeback writes data and clears busy
//   flush                    : squash all pending writes
//   busy_any, busy_cnt       : scoreboard summary of registered state
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush,
  output logic                     busy_any,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [NREGS-1:0]  busy_vec;
  logic              wr_ok;

  // Writes to a hardwired zero register are dropped.
  assign wr_ok = wb_en && !(ZERO_REG != 0 && wb_addr == '0);

  // Reset must clear storage asynchronously, so this is a flop array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_reg[wb_addr] <= wb_data;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .flush    (flush),
    .busy     (busy_vec),
    .busy_cnt (busy_cnt),
    .busy_any (busy_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_sel;
      logic              busy_sel;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Zero register first, then bypass of the in-flight writeback
      // (which also hides the busy bit it is about to clear), then storage.
      always_comb begin
        data_sel = regs_reg[addr];
        busy_sel = busy_vec[addr];
        if (ZERO_REG != 0 && addr == '0) begin
          data_sel = '0;
          busy_sel = 1'b0;
        end else if (wb_en && wb_addr == addr) begin
          data_sel = wb_data;
          busy_sel = 1'b0;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_sel;
      assign rd_busy[gi]                  = busy_sel;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus, index 0 = default DUT (32b, 32 regs, 2 ports, zero reg),
  // index 1 = sweep DUT (16b, 8 regs, 4 ports, no zero reg).
  logic [4:0]  rd_addr [2][4];
  logic        iss_en  [2];
  logic [4:0]  iss_addr[2];
  logic        wb_en   [2];
  logic [4:0]  wb_addr [2];
  logic [31:0] wb_data [2];
  logic        flush   [2];

  logic [63:0] rd_data0;
  logic [1:0]  rd_busy0;
  logic        busy_any0;
  logic [5:0]  busy_cnt0;
  logic [63:0] rd_data1;
  logic [3:0]  rd_busy1;
  logic        busy_any1;
  logic [3:0]  busy_cnt1;

  regfile_sb dut0 (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  ({rd_addr[0][1], rd_addr[0][0]}),
    .rd_data  (rd_data0),
    .rd_busy  (rd_busy0),
    .iss_en   (iss_en[0]),
    .iss_addr (iss_addr[0]),
    .wb_en    (wb_en[0]),
    .wb_addr  (wb_addr[0]),
    .wb_data  (wb_data[0]),
    .flush    (flush[0]),
    .busy_any (busy_any0),
    .busy_cnt (busy_cnt0)
  );

  regfile_sb #(.DATA_W(16), .NREGS(8), .NUM_RD(4), .ZERO_REG(0)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  ({rd_addr[1][3][2:0], rd_addr[1][2][2:0], rd_addr[1][1][2:0], rd_addr[1][0][2:0]}),
    .rd_data  (rd_data1),
    .rd_busy  (rd_busy1),
    .iss_en   (iss_en[1]),
    .iss_addr (iss_addr[1][2:0]),
    .wb_en    (wb_en[1]),
    .wb_addr  (wb_addr[1][2:0]),
    .wb_data  (wb_data[1][15:0]),
    .flush    (flush[1]),
    .busy_any (busy_any1),
    .busy_cnt (busy_cnt1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: plain arrays of register contents and pending flags.
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];
  int          nregs [2] = '{32, 8};
  int          nrd   [2] = '{2, 4};
  bit          zr    [2] = '{1'b1, 1'b0};
  logic [31:0] dmask [2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

  function automatic void model_read(input int d, input int a,
                                     output logic [31:0] data, output bit busy);
    if (zr[d] && a == 0) begin
      data = 0; busy = 0;
    end else if (wb_en[d] && int'(wb_addr[d]) == a) begin
      data = wb_data[d] & dmask[d]; busy = 0;
    end else begin
      data = m_regs[d][a]; busy = m_busy[d][a];
    end
  endfunction

  // Compare on the falling edge, then advance the model by the rising
  // edge that follows (inputs are held from rising edge + 1).
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int r = 0; r < 32; r++) begin
          m_regs[d][r] = 0; m_busy[d][r] = 0;
        end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int cnt;
        logic [31:0] ed, ad;
        bit eb, ab;
        for (int p = 0; p < nrd[d]; p++) begin
          model_read(d, int'(rd_addr[d][p]), ed, eb);
          ad = (d == 0) ? rd_data0[p*32 +: 32] : {16'h0, rd_data1[p*16 +: 16]};
          ab = (d == 0) ? rd_busy0[p] : rd_busy1[p];
          check($sformatf("dut%0d rd_data[%0d] addr %0d", d, p, rd_addr[d][p]), 64'(ad), 64'(ed));
          check($sformatf("dut%0d rd_busy[%0d] addr %0d", d, p, rd_addr[d][p]), 64'(ab), 64'(eb));
        end
        cnt = 0;
        for (int r = 0; r < nregs[d]; r++) cnt += int'(m_busy[d][r]);
        check($sformatf("dut%0d busy_cnt", d), (d == 0) ? 64'(busy_cnt0) : 64'(busy_cnt1), 64'(cnt));
        check($sformatf("dut%0d busy_any", d), (d == 0) ? 64'(busy_any0) : 64'(busy_any1), 64'(cnt != 0));
        // Apply the coming edge: writeback, then flush, then issue last so it wins.
        if (wb_en[d]) begin
          if (!(zr[d] && wb_addr[d] == 0)) m_regs[d][wb_addr[d]] = wb_data[d] & dmask[d];
          m_busy[d][wb_addr[d]] = 0;
        end
        if (flush[d]) for (int r = 0; r < 32; r++) m_busy[d][r] = 0;
        if (iss_en[d] && !(zr[d] && iss_addr[d] == 0)) m_busy[d][iss_addr[d]] = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      iss_en[d] = 0; wb_en[d] = 0; flush[d] = 0;
      iss_addr[d] = 0; wb_addr[d] = 0; wb_data[d] = 0;
    end
  endtask

  task automatic rd0(input int a0, input int a1);
    rd_addr[0][0] = 5'(a0); rd_addr[0][1] = 5'(a1);
  endtask

  task automatic iss0(input int a);
    tick(); iss_en[0] = 1; iss_addr[0] = 5'(a);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iss_en[d] = 0; wb_en[d] = 0; flush[d] = 0;
      iss_addr[d] = 0; wb_addr[d] = 0; wb_data[d] = 0;
      for (int p = 0; p < 4; p++) rd_addr[d][p] = 0;
    end
    rd0(1, 2);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy_cnt", 64'(busy_cnt0), 64'd0);
    check("reset busy_any", 64'(busy_any0), 64'd0);
    check("reset rd_data", rd_data0, 64'd0);
    rst = 0;

    // Plain writes, then read back from storage.
    tick(); wb_en[0] = 1; wb_addr[0] = 1; wb_data[0] = 32'h1111_1111;
    tick(); wb_en[0] = 1; wb_addr[0] = 2; wb_data[0] = 32'h2222_2222;
    tick(); #1;
    check("storage read r1/r2", rd_data0, 64'h2222_2222_1111_1111);

    // Issue 7, 3, 4, 9.
    iss0(7); iss0(3); iss0(4); iss0(9);
    tick(); rd0(7, 3); #1;
    check("busy after issue", 64'(rd_busy0), 64'b11);
    check("busy_cnt after issue", 64'(busy_cnt0), 64'd4);

    // Writeback to busy r3 bypasses and hides its busy bit.
    tick(); wb_en[0] = 1; wb_addr[0] = 3; wb_data[0] = 32'h3333_3333; rd0(3, 4); #1;
    check("wb clears busy same cycle", 64'(rd_busy0), 64'b10);
    tick(); #1;
    check("busy_cnt after wb", 64'(busy_cnt0), 64'd3);

    // Bypass of a fresh value, then the same value from storage.
    tick(); wb_en[0] = 1; wb_addr[0] = 5; wb_data[0] = 32'hDEAD_BEEF; rd0(5, 5); #1;
    check("bypass data", 64'(rd_data0[31:0]), 64'hDEAD_BEEF);
    check("bypass busy", 64'(rd_busy0[0]), 64'd0);
    tick(); #1;
    check("stored after bypass", 64'(rd_data0[31:0]), 64'hDEAD_BEEF);

    // Zero register ignores writes and issues.
    tick(); wb_en[0] = 1; wb_addr[0] = 0; wb_data[0] = 32'h1234;
    iss_en[0] = 1; iss_addr[0] = 0; rd0(0, 0); #1;
    check("r0 read during write", rd_data0, 64'd0);
    tick(); #1;
    check("r0 stays zero", rd_data0, 64'd0);
    check("r0 issue ignored", 64'(busy_cnt0), 64'd3);

    // Issue and writeback to r7 in the same cycle: data lands, r7 stays busy.
    tick(); iss_en[0] = 1; iss_addr[0] = 7; wb_en[0] = 1; wb_addr[0] = 7;
    wb_data[0] = 32'h7777_7777; rd0(7, 7);
    tick(); #1;
    check("r7 data after iss+wb", 64'(rd_data0[31:0]), 64'h7777_7777);
    check("r7 still busy", 64'(rd_busy0[0]), 64'd1);
    check("busy_cnt after iss+wb", 64'(busy_cnt0), 64'd3);

    // Busy 3,4,7,9; flush together with issue to 12.
    iss0(3);
    tick(); flush[0] = 1; iss_en[0] = 1; iss_addr[0] = 12; rd0(12, 3);
    tick(); #1;
    check("flush+issue busy_cnt", 64'(busy_cnt0), 64'd1);
    check("flush+issue busy", 64'(rd_busy0), 64'b01);

    // Asynchronous reset in the middle of activity.
    tick(); iss_en[0] = 1; iss_addr[0] = 2; wb_en[0] = 1; wb_addr[0] = 1; wb_data[0] = 32'hAAAA_5555;
    tick(); rd0(1, 12); rst = 1; #1;
    check("async reset rd_data", rd_data0, 64'd0);
    check("async reset busy_cnt", 64'(busy_cnt0), 64'd0);
    check("async reset busy_any", 64'(busy_any0), 64'd0);
    check("async reset rd_busy", 64'(rd_busy0), 64'd0);
    @(negedge clk);
    @(posedge clk); #1; rst = 0;

    // Sweep DUT: fill all 8 registers (r0 included), then make r0 busy.
    for (int i = 0; i < 8; i++) begin
      tick(); wb_en[1] = 1; wb_addr[1] = 5'(i); wb_data[1] = 32'hA000 | (32'(i) * 32'h111);
    end
    tick(); iss_en[1] = 1; iss_addr[1] = 0;
    tick();
    rd_addr[1][0] = 0; rd_addr[1][1] = 3; rd_addr[1][2] = 5; rd_addr[1][3] = 7; #1;
    check("sweep 4-port read", rd_data1, 64'hA777_A555_A333_A000);
    check("sweep r0 busy", 64'(rd_busy1), 64'b0001);
    check("sweep busy_cnt", 64'(busy_cnt1), 64'd1);

    // Mixed random traffic on both DUTs, checked by the model every cycle.
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        iss_en[d]   = ($urandom_range(0, 2) == 0);
        iss_addr[d] = 5'($urandom_range(0, nregs[d] - 1));
        wb_en[d]    = ($urandom_range(0, 1) == 0);
        wb_addr[d]  = 5'($urandom_range(0, nregs[d] - 1));
        wb_data[d]  = $urandom & dmask[d];
        flush[d]    = ($urandom_range(0, 15) == 0);
        for (int p = 0; p < 4; p++) rd_addr[d][p] = 5'($urandom_range(0, nregs[d] - 1));
        if ($urandom_range(0, 3) == 0) rd_addr[d][0] = wb_addr[d];
      end
    end
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
